spm_bank_rd_stream: RTL
=======================

SPM_BANK_RD_STREAM -- requirements
Module: spm_bank_rd_stream

Interface
REQ-001 Parameter NUM_LANE, default 128, number of lanes per bank row.
REQ-002 Parameter DATA_WIDTH, default 64, bits per lane.
REQ-003 Parameter URAM_ADDR_WIDTH, default 12, bank row address width (AW).
REQ-004 Parameter URAM_DEPTH, default 4096, number of bank rows.
REQ-005 Parameter RD_LAT, default 4, cycles from bank enable to valid read data.
REQ-006 Parameter FIFO_DEPTH, default 8, output buffer rows; SHALL be >= RD_LAT+2.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 i_cmd_valid / o_cmd_ready  in/out  1 each  command handshake.
REQ-010 i_cmd_addr  input  AW  first row to read.
REQ-011 i_cmd_len  input  AW+1  rows to read, 0..URAM_DEPTH.
REQ-012 o_bank_addr_a / o_bank_en_a / o_bank_wr_en_a  output  AW/1/1  bank port A read request; wr_en constant 0.
REQ-013 i_bank_rd_data_a  input  DATA_WIDTH*NUM_LANE  bank port A read data.
REQ-014 o_data_valid / i_data_ready  out/in  1 each  row stream handshake.
REQ-015 o_data  output  DATA_WIDTH*NUM_LANE  row at stream head.
REQ-016 o_busy / o_done  output  1 each  command active / one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN; IDLE->ISSUE on accepted command with len>0; ISSUE->DRAIN after last request issued; DRAIN->IDLE on final stream handshake.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE; command accepted when i_cmd_valid & o_cmd_ready.
REQ-019 len=0 command: accepted, no bank requests, o_done=1 the next cycle, FSM stays IDLE.
REQ-020 In ISSUE, o_bank_en_a=1 iff (in-flight reads + FIFO occupancy) < FIFO_DEPTH; same-cycle pops not credited.
REQ-021 First request in cycle after accept at i_cmd_addr; each request increments address by 1, wrapping URAM_DEPTH-1 -> 0.
REQ-022 Read data captured into FIFO at the edge ending cycle E+RD_LAT for request issued in cycle E, via RD_LAT-deep valid shift register.
REQ-023 FIFO SHALL never overflow; rows emerge in request order; o_data_valid = FIFO non-empty; o_data = FIFO head, stable while valid & !ready.
REQ-024 Simultaneous push and pop SHALL be legal at any occupancy including full and empty-with-push (no bypass: pushed row visible next cycle).
REQ-025 With i_data_ready held 1, sustained throughput SHALL be one row per cycle; first o_data_valid at cycle T+RD_LAT+2 for accept at T.
REQ-026 o_done SHALL pulse 1 cycle after final row handshake; o_cmd_ready high in that same cycle.
REQ-027 o_busy = (state != IDLE).
REQ-028 i_cmd_valid while busy SHALL be ignored (not accepted, no effect).

Reset
REQ-029 While rst=1: state IDLE, o_cmd_ready=0, o_bank_en_a=0, o_bank_addr_a=0, o_data_valid=0, o_done=0, o_busy=0, FIFO and in-flight tracker cleared.
REQ-030 Reset mid-operation SHALL discard in-flight reads and buffered rows; data returning after reset SHALL not be captured; o_cmd_ready=1 first cycle after rst falls.

Verification
REQ-031 addr=0x010, len=4, ready=1 -> en in 4 consecutive cycles, addrs 0x010..0x013, 4 rows out back-to-back starting T+6, done at last+1.
REQ-032 addr=0xFFE, len=4 -> request addrs 0xFFE,0xFFF,0x000,0x001 in that order.
REQ-033 len=20, i_data_ready=0 -> exactly 8 requests issued then en=0, o_data held stable; release ready -> remaining 12 issued, all 20 rows in order.
REQ-034 len=0 -> no en, o_done one cycle after accept; new command accepted following cycle.
REQ-035 rst asserted 2 cycles into len=16 command -> outputs at reset values, no stale row appears after rst falls, next command len=2 returns exactly 2 correct rows.
REQ-036 random i_data_ready toggling, len=URAM_DEPTH -> all 4096 rows delivered in order, no drops or duplicates, in-flight+occupancy never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/spm_bank_rd_stream.sv
// Streams a run of consecutive bank rows out of a fixed-latency scratchpad port.
// A credit count (requests issued but not yet popped) keeps the output FIFO from overflowing.
module spm_bank_rd_stream #(
  parameter int NUM_LANE        = 128,
  parameter int DATA_WIDTH      = 64,
  parameter int URAM_ADDR_WIDTH = 12,
  parameter int URAM_DEPTH      = 4096,
  parameter int RD_LAT          = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_cmd_valid,
  output logic                                o_cmd_ready,
  input  logic [URAM_ADDR_WIDTH-1:0]          i_cmd_addr,
  input  logic [URAM_ADDR_WIDTH:0]            i_cmd_len,
  output logic [URAM_ADDR_WIDTH-1:0]          o_bank_addr_a,
  output logic                                o_bank_en_a,
  output logic                                o_bank_wr_en_a,
  input  logic [DATA_WIDTH*NUM_LANE-1:0]      i_bank_rd_data_a,
  output logic                                o_data_valid,
  input  logic                                i_data_ready,
  output logic [DATA_WIDTH*NUM_LANE-1:0]      o_data,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int AW = URAM_ADDR_WIDTH;
  localparam int RW = DATA_WIDTH * NUM_LANE;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(URAM_DEPTH - 1);
  localparam logic [AW:0]   LEN_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       iss_rem_q, iss_rem_d;
  logic [AW:0]       out_rem_q, out_rem_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              done_q, done_d;
  logic [RW-1:0]     mem_q [FIFO_DEPTH];

  logic accept, issue, push, pop;

  always_comb begin
    accept = (state_q == IDLE) && i_cmd_valid;
    issue  = (state_q == ISSUE) && (cred_q < DEPTH_C);
    push   = vld_q[RD_LAT-1];
    pop    = (cnt_q != CNT_ZERO) && i_data_ready;

    state_d   = state_q;
    addr_d    = addr_q;
    iss_rem_d = iss_rem_q;
    out_rem_d = pop ? (out_rem_q - LEN_ONE) : out_rem_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_cmd_len == LEN_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            addr_d    = i_cmd_addr;
            iss_rem_d = i_cmd_len;
            out_rem_d = i_cmd_len;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d    = (addr_q == ADDR_LAST) ? ADDR_ZERO : (addr_q + ADDR_ONE);
          iss_rem_d = iss_rem_q - LEN_ONE;
          if (iss_rem_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_rem_q == LEN_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bit k set means a read issued k+1 cycles ago is still on its way back.
    vld_d = RD_LAT'({vld_q, issue});

    case ({issue, pop})
      2'b10:   cred_d = cred_q + CNT_ONE;
      2'b01:   cred_d = cred_q - CNT_ONE;
      default: cred_d = cred_q;
    endcase

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d = push ? ((wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE)) : wr_ptr_q;
    rd_ptr_d = pop  ? ((rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE)) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= ADDR_ZERO;
      iss_rem_q <= LEN_ZERO;
      out_rem_q <= LEN_ZERO;
      cred_q    <= CNT_ZERO;
      cnt_q     <= CNT_ZERO;
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      vld_q     <= {RD_LAT{1'b0}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iss_rem_q <= iss_rem_d;
      out_rem_q <= out_rem_d;
      cred_q    <= cred_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  // Row storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= i_bank_rd_data_a;
    end
  end

  assign o_cmd_ready    = !rst && (state_q == IDLE);
  assign o_bank_en_a    = !rst && issue;
  assign o_bank_addr_a  = rst ? ADDR_ZERO : addr_q;
  assign o_bank_wr_en_a = 1'b0;
  assign o_data_valid   = !rst && (cnt_q != CNT_ZERO);
  assign o_data         = mem_q[rd_ptr_q];
  assign o_busy         = !rst && (state_q != IDLE);
  assign o_done         = !rst && done_q;

endmodule
